// File: rtl/mem_burst_rw_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_rw_if
//  Description : Bundle of request, memory and completion signals used by
//                mem_burst_rw.
//                  slave  - view taken by the sequencer (accepts requests and
//                           drives the byte-wide memory bus)
//                  master - view taken by the requester / memory model
//                Signals:
//                  req_valid/req_ready/req_write/req_len/req_addr/req_wdata
//                  mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_ack
//                  done/err/rdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_burst_rw_if #(
    parameter int ADDR_W    = 16,
    parameter int MAX_BYTES = 4
);
    localparam int c_LW = $clog2(MAX_BYTES);
    localparam int c_DW = 8 * MAX_BYTES;

    // Request side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [c_LW-1:0]   req_len;
    logic [ADDR_W-1:0] req_addr;
    logic [c_DW-1:0]   req_wdata;

    // Byte-wide memory side
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    // Completion
    logic              done;
    logic              err;
    logic [c_DW-1:0]   rdata;

    modport slave (
        input  req_valid, req_write, req_len, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output done, err, rdata
    );

    modport master (
        output req_valid, req_write, req_len, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  done, err, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_burst_rw.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_rw
//  Description : Byte-serial memory transaction sequencer. Accepts one request
//                of 1..MAX_BYTES bytes and issues one byte access per memory
//                handshake, with a one-cycle idle gap between bytes. Read
//                bytes are assembled little-endian into rdata. Each byte
//                waits at most TIMEOUT cycles for mem_ack before the request
//                is aborted with err.
//  Ports       : clk  - system clock (rising edge)
//                rst  - synchronous active-high reset
//                bus  - mem_burst_rw_if.slave (request, memory, completion)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_rw #(
    parameter int ADDR_W    = 16,
    parameter int MAX_BYTES = 4,
    parameter int TIMEOUT   = 15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_burst_rw_if.slave      bus
);
    localparam int c_LW = $clog2(MAX_BYTES);
    localparam int c_DW = 8 * MAX_BYTES;
    localparam int c_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;

    // Latched request
    logic              r_write;
    logic [c_LW-1:0]   r_len;
    logic [ADDR_W-1:0] r_base;
    logic [c_DW-1:0]   r_wdata;

    // Progress
    logic [c_LW-1:0]   r_idx;
    logic [c_TW-1:0]   r_tmo;

    // Registered outputs
    logic              r_req_ready;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_done;
    logic              r_err;
    logic [c_DW-1:0]   r_rdata;

    logic              w_last;
    logic              w_tmo_hit;
    logic [c_LW+2:0]   w_byte_sel;
    logic [ADDR_W-1:0] w_cur_addr;

    assign w_last     = (r_idx == r_len);
    // The wait cycle with counter = TIMEOUT-1 is the TIMEOUT-th one, so the
    // abort happens after exactly TIMEOUT cycles of mem_en without ack.
    assign w_tmo_hit  = (r_tmo == c_TW'(TIMEOUT - 1));
    assign w_byte_sel = {r_idx, 3'b000};
    // Natural ADDR_W-bit overflow gives the required address wrap.
    assign w_cur_addr = r_base + ADDR_W'(r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_len       <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_req_ready <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_write     <= bus.req_write;
                        r_len       <= bus.req_len;
                        r_base      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_idx       <= '0;
                        r_tmo       <= '0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_req_ready <= 1'b0;
                        // First byte goes out directly on the accept edge.
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= bus.req_write;
                        r_mem_addr  <= bus.req_addr;
                        r_mem_wdata <= bus.req_wdata[7:0];
                        r_state     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (bus.mem_ack) begin
                        if (!r_write) begin
                            r_rdata[w_byte_sel +: 8] <= bus.mem_rdata;
                        end
                        r_mem_en <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_GAP;
                        end
                    end else if (w_tmo_hit) begin
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_mem_en <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_GAP: begin
                    // r_idx already points at the next byte here.
                    r_tmo       <= '0;
                    r_mem_en    <= 1'b1;
                    r_mem_addr  <= w_cur_addr;
                    r_mem_wdata <= r_wdata[w_byte_sel +: 8];
                    r_state     <= ST_XFER;
                end

                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_mem_en    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_rw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_burst_rw
//  Description : Directed self-checking bench for mem_burst_rw. Drives
//                requests and acts as the byte-wide memory; expected
//                addresses, bytes, read words and completion cycles are
//                hand-derived constants in each vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_rw;
    localparam int ADDR_W    = 16;
    localparam int MAX_BYTES = 4;
    localparam int TIMEOUT   = 15;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    always #5 tb_clk = ~tb_clk;

    mem_burst_rw_if #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) bus ();

    mem_burst_rw #(
        .ADDR_W    (ADDR_W),
        .MAX_BYTES (MAX_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; everything after this sees the post-edge values.
    task automatic tick();
        @(posedge tb_clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_len   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // One complete request. dly = no-ack cycles before each ack, ack_bytes =
    // number of bytes that ever get acked (fewer than len+1 forces a
    // timeout), gap_ack holds mem_ack high through the GAP/DONE cycles.
    task automatic run_req(input string name, input bit wr, input int len,
                           input logic [15:0] addr, input logic [31:0] wdata,
                           input int dly, input logic [31:0] rsrc,
                           input int ack_bytes, input bit gap_ack,
                           input logic [31:0] exp_rdata, input bit exp_err,
                           input int exp_done);
        int          guard;
        logic [15:0] a_exp;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk({name, " ready"}, bus.req_ready, 1'b1);

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_len   = 2'(len);
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        cyc = 1;
        // Scramble request inputs so only the latched copy can be used.
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'hDEAD;
        bus.req_wdata = ~wdata;
        bus.req_write = ~wr;
        chk({name, " busy"}, bus.req_ready, 1'b0);

        for (int k = 0; k <= len; k++) begin
            a_exp = addr + 16'(k);
            if (k >= ack_bytes) begin
                for (int t = 0; t < TIMEOUT; t++) begin
                    chk($sformatf("%s b%0d tmo en", name, k), bus.mem_en, 1'b1);
                    chk($sformatf("%s b%0d tmo addr", name, k), bus.mem_addr, a_exp);
                    chk($sformatf("%s b%0d tmo done", name, k), bus.done, 1'b0);
                    tick();
                end
                break;
            end
            for (int d = 0; d < dly; d++) begin
                chk($sformatf("%s b%0d wait en", name, k), bus.mem_en, 1'b1);
                chk($sformatf("%s b%0d wait addr", name, k), bus.mem_addr, a_exp);
                tick();
            end
            chk($sformatf("%s b%0d en", name, k), bus.mem_en, 1'b1);
            chk($sformatf("%s b%0d wr", name, k), bus.mem_wr, wr);
            chk($sformatf("%s b%0d addr", name, k), bus.mem_addr, a_exp);
            if (wr) chk($sformatf("%s b%0d wdata", name, k), bus.mem_wdata, wdata[8*k +: 8]);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rsrc[8*k +: 8];
            tick();
            bus.mem_ack   = gap_ack;
            bus.mem_rdata = 8'hEE;
            if (k < len) begin
                chk($sformatf("%s b%0d gap en", name, k), bus.mem_en, 1'b0);
                chk($sformatf("%s b%0d gap done", name, k), bus.done, 1'b0);
                tick();
                bus.mem_ack = 1'b0;
            end
        end

        chk({name, " done"}, bus.done, 1'b1);
        chk({name, " err"}, bus.err, exp_err);
        chk({name, " rdata"}, bus.rdata, exp_rdata);
        chk({name, " done cycle"}, 64'(cyc), 64'(exp_done));
        chk({name, " done en"}, bus.mem_en, 1'b0);
        tick();
        bus.mem_ack = 1'b0;
        chk({name, " done pulse"}, bus.done, 1'b0);
        chk({name, " ready after"}, bus.req_ready, 1'b1);
        chk({name, " rdata held"}, bus.rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with random inputs.
        rst           = 1'b1;
        bus.req_valid = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_len   = 2'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;
        bus.mem_ack   = 1'($urandom);
        bus.mem_rdata = 8'($urandom);
        tick();
        bus.req_valid = 1'b1;
        bus.mem_ack   = 1'b1;
        tick();
        chk("rst ready", bus.req_ready, 1'b1);
        chk("rst en", bus.mem_en, 1'b0);
        chk("rst wr", bus.mem_wr, 1'b0);
        chk("rst addr", bus.mem_addr, 16'h0000);
        chk("rst wdata", bus.mem_wdata, 8'h00);
        chk("rst done", bus.done, 1'b0);
        chk("rst err", bus.err, 1'b0);
        chk("rst rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        idle_inputs();
        tick();

        // Single-byte read.
        run_req("rd1", 1'b0, 0, 16'h1234, 32'h0, 0, 32'h000000A5, 1, 1'b0,
                32'h000000A5, 1'b0, 2);
        // Timeout on byte 1 of a 2-byte read.
        run_req("tmo", 1'b0, 1, 16'h2000, 32'h0, 0, 32'hFFFFFF7E, 1, 1'b0,
                32'h0000007E, 1'b1, 18);
        // 4-byte write wrapping the address space; rdata and err must clear.
        run_req("wr4", 1'b1, 3, 16'hFFFE, 32'h44332211, 0, 32'h0, 4, 1'b0,
                32'h00000000, 1'b0, 8);
        // 2-byte read, each ack delayed three cycles.
        run_req("rd2dly", 1'b0, 1, 16'h0400, 32'h0, 3, 32'h00004569, 2, 1'b0,
                32'h00004569, 1'b0, 10);
        // 3-byte read with mem_ack left high outside XFER.
        run_req("rd3", 1'b0, 2, 16'h0010, 32'h0, 0, 32'h99CCBBAA, 3, 1'b1,
                32'h00CCBBAA, 1'b0, 6);

        // Reset in the middle of a 4-byte write, with a request while busy.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_len   = 2'd3;
        bus.req_addr  = 16'h0100;
        bus.req_wdata = 32'hDDCCBBAA;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0F00;
        tick();
        chk("rstmid b1 addr", bus.mem_addr, 16'h0101);
        chk("rstmid b1 wdata", bus.mem_wdata, 8'hBB);
        chk("rstmid busy ready", bus.req_ready, 1'b0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        chk("rstmid b2 en", bus.mem_en, 1'b1);
        chk("rstmid b2 addr", bus.mem_addr, 16'h0102);
        chk("rstmid b2 wdata", bus.mem_wdata, 8'hCC);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        chk("rstmid en", bus.mem_en, 1'b0);
        chk("rstmid done", bus.done, 1'b0);
        chk("rstmid ready", bus.req_ready, 1'b1);
        chk("rstmid addr", bus.mem_addr, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstmid quiet%0d en", i), bus.mem_en, 1'b0);
            chk($sformatf("rstmid quiet%0d done", i), bus.done, 1'b0);
        end
        idle_inputs();

        // Block still usable after the mid-burst reset.
        run_req("post", 1'b0, 1, 16'h3000, 32'h0, 1, 32'h00005A3C, 2, 1'b0,
                32'h00005A3C, 1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
